// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer.
// Opcodes, FSM state encoding and DIN opcode field position.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_HALTED,
    S_ERROR
  } state_e;

  function automatic logic [2:0] opcode(input logic [15:0] w);
    return w[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Handshake watchdog: counts enabled cycles, flags the last
// cycle before TIMEOUT is reached so the caller can bail out.
module seq_watchdog #(
  parameter int TIMEOUT = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = en_i && !clr_i
                  && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/proc_sequencer.sv
// Fetches ROM words and feeds them to the multi-cycle processor,
// supplying mvi immediates in T1 and stopping on HALT/Stop/timeout.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  input  logic [ADDR_W-1:0] StartAddr,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [15:0]       MemData,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Err,
  output logic [15:0]       InstrCount
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              first_q, first_d;
  logic              wd_expired;
  logic              in_exec;

  assign in_exec = (state_q == S_EXEC);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk_i     (Clock),
    .rst_ni    (Resetn),
    .clr_i     (!in_exec || Done),
    .en_i      (in_exec),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    first_d = 1'b0;
    Run     = 1'b0;
    DIN     = '0;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          pc_d    = StartAddr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = Stop ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        if (opcode(MemData) == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          Run     = 1'b1;
          DIN     = MemData;
          op_d    = opcode(MemData);
          first_d = 1'b1;
          state_d = S_EXEC;
          // Skip past the immediate word; it is read during ISSUE.
          if (opcode(MemData) == OP_MVI)
            pc_d = pc_q + ADDR_W'(1);
        end
      end
      S_EXEC: begin
        Run = 1'b1;
        if (first_q && op_q == OP_MVI) DIN = MemData;
        if (Done) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = Stop ? S_IDLE : S_FETCH;
        end else if (wd_expired) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      op_q    <= OP_MV;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      first_q <= first_d;
    end
  end

  assign MemAddr    = pc_q;
  assign InstrCount = cnt_q;
  assign Halted     = (state_q == S_HALTED);
  assign Err        = (state_q == S_ERROR);
  assign Busy       = (state_q == S_FETCH)
                   || (state_q == S_ISSUE)
                   || in_exec;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: ROM model, processor model and an
// interpreter-style reference for randomized programs.
module tb_proc_sequencer;

  localparam int AW = 5;
  localparam int TO = 8;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Start = 1'b0;
  logic          Stop = 1'b0;
  logic [AW-1:0] StartAddr = '0;
  logic [AW-1:0] MemAddr;
  logic [15:0]   MemData = '0;
  logic [15:0]   DIN;
  logic          Run;
  logic          Done;
  logic          Busy;
  logic          Halted;
  logic          Err;
  logic [15:0]   InstrCount;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [32];

  proc_sequencer #(
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Start      (Start),
    .Stop       (Stop),
    .StartAddr  (StartAddr),
    .MemAddr    (MemAddr),
    .MemData    (MemData),
    .DIN        (DIN),
    .Run        (Run),
    .Done       (Done),
    .Busy       (Busy),
    .Halted     (Halted),
    .Err        (Err),
    .InstrCount (InstrCount)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) MemData <= rom[MemAddr];

  // Processor model: T0 loads IR, mv/mvi finish in T1, add/sub in T3.
  logic [1:0]  T;
  logic [15:0] IR;
  logic [15:0] R [8];
  logic        nodone = 1'b0;

  assign Done = !nodone
             && ((T == 2'd1 && IR[8:7] == 2'b00)
              || (T == 2'd3 && IR[8:7] == 2'b01));

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      T  <= '0;
      IR <= '0;
      for (int i = 0; i < 8; i++) R[i] <= '0;
    end else if (Run) begin
      if (T == 2'd0) begin
        IR <= DIN;
        T  <= 2'd1;
      end else begin
        if (T == 2'd1 && IR[8:6] == 3'b000) R[IR[5:3]] <= R[IR[2:0]];
        if (T == 2'd1 && IR[8:6] == 3'b001) R[IR[5:3]] <= DIN;
        if (Done && IR[8:6] == 3'b010)
          R[IR[5:3]] <= R[IR[5:3]] + R[IR[2:0]];
        if (Done && IR[8:6] == 3'b011)
          R[IR[5:3]] <= R[IR[5:3]] - R[IR[2:0]];
        T <= Done ? 2'd0 : T + 2'd1;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Start  = 1'b0;
    Stop   = 1'b0;
    step();
    Resetn = 1'b1;
    step();
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    StartAddr = a;
    Start     = 1'b1;
    step();
    Start     = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!Halted && !Err && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'b0, Halted}, 32'd1);
  endtask

  logic [15:0] refR [8];
  logic [AW-1:0] a, sa;
  int n, lat, ni, op, x, y;
  logic [15:0] imm;

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = '0;
    #2;
    check("rst_run",    {31'b0, Run},    32'd0);
    check("rst_din",    {16'b0, DIN},    32'd0);
    check("rst_busy",   {31'b0, Busy},   32'd0);
    check("rst_halted", {31'b0, Halted}, 32'd0);
    check("rst_err",    {31'b0, Err},    32'd0);
    check("rst_pc",     {27'b0, MemAddr}, 32'd0);
    check("rst_cnt",    {16'b0, InstrCount}, 32'd0);
    step();
    Resetn = 1'b1;
    step();

    // mvi R0,#5 ; HALT
    rom[0] = 16'h0040; rom[1] = 16'h0005; rom[2] = 16'h01C0;
    pulse_start(5'd0);
    step();
    check("t1_issue_run", {31'b0, Run}, 32'd1);
    check("t1_issue_din", {16'b0, DIN}, 32'h0040);
    step();
    check("t1_imm_run", {31'b0, Run}, 32'd1);
    check("t1_imm_din", {16'b0, DIN}, 32'h0005);
    wait_halt("t1_halt", 20);
    check("t1_r0",   {16'b0, R[0]}, 32'd5);
    check("t1_cnt",  {16'b0, InstrCount}, 32'd1);
    check("t1_pc",   {27'b0, MemAddr}, 32'd3);
    check("t1_busy", {31'b0, Busy}, 32'd0);
    pulse_start(5'd0);
    wait_halt("t1_restart", 20);
    check("t1_cnt2", {16'b0, InstrCount}, 32'd2);

    // mvi R1,#3 ; mvi R2,#4 ; add R1,R2 ; HALT at address 4
    do_reset();
    rom[4] = 16'h0048; rom[5] = 16'd3;
    rom[6] = 16'h0050; rom[7] = 16'd4;
    rom[8] = 16'h008A; rom[9] = 16'h01C0;
    pulse_start(5'd4);
    n = 0;
    while (!(Run && DIN == 16'h008A) && n < 30) begin
      step();
      n++;
    end
    check("t2_add_seen", {16'b0, DIN}, 32'h008A);
    StartAddr = 5'd17;
    Start = 1'b1;
    n = 0;
    while (Run && n < 10) begin
      step();
      n++;
    end
    Start = 1'b0;
    check("t2_add_run_cycles", n, 32'd4);
    wait_halt("t2_halt", 20);
    check("t2_r1",   {16'b0, R[1]}, 32'd7);
    check("t2_cnt",  {16'b0, InstrCount}, 32'd3);
    check("t2_busy", {31'b0, Busy}, 32'd0);
    check("t2_pc",   {27'b0, MemAddr}, 32'd10);

    // Stop in the Done cycle of the first instruction
    do_reset();
    rom[0] = 16'h0040; rom[1] = 16'h0001;
    rom[2] = 16'h0008; rom[3] = 16'h0010; rom[4] = 16'h01C0;
    pulse_start(5'd0);
    n = 0;
    while (!Done && n < 10) begin
      step();
      n++;
    end
    check("t3_done_seen", {31'b0, Done}, 32'd1);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    check("t3_busy", {31'b0, Busy}, 32'd0);
    check("t3_run",  {31'b0, Run}, 32'd0);
    check("t3_cnt",  {16'b0, InstrCount}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_pc_hold", {27'b0, MemAddr}, 32'd2);
    end
    check("t3_r1_untouched", {16'b0, R[1]}, 32'd0);

    // mvi at the last address, immediate wraps to address 0
    do_reset();
    rom[31] = 16'h0040; rom[0] = 16'hBEEF; rom[1] = 16'h01C0;
    pulse_start(5'd31);
    step();
    check("t4_issue_din", {16'b0, DIN}, 32'h0040);
    step();
    check("t4_imm_din", {16'b0, DIN}, 32'hBEEF);
    check("t4_pc",      {27'b0, MemAddr}, 32'd1);
    wait_halt("t4_halt", 20);
    check("t4_r0",      {16'b0, R[0]}, 32'hBEEF);
    check("t4_pc_halt", {27'b0, MemAddr}, 32'd2);

    // Done never arrives: error after TIMEOUT cycles in EXEC
    do_reset();
    nodone = 1'b1;
    rom[0] = 16'h0000;
    pulse_start(5'd0);
    step();
    check("t5_issue_run", {31'b0, Run}, 32'd1);
    step();
    for (int k = 1; k < TO; k++) begin
      step();
      check("t5_exec_err", {31'b0, Err}, 32'd0);
      check("t5_exec_run", {31'b0, Run}, 32'd1);
    end
    step();
    check("t5_err",  {31'b0, Err}, 32'd1);
    check("t5_run",  {31'b0, Run}, 32'd0);
    check("t5_busy", {31'b0, Busy}, 32'd0);
    pulse_start(5'd3);
    step();
    check("t5_err_held", {31'b0, Err}, 32'd1);

    // Asynchronous reset in the middle of EXEC
    do_reset();
    pulse_start(5'd0);
    step(2);
    check("t6_pre_run", {31'b0, Run}, 32'd1);
    Resetn = 1'b0;
    #1;
    check("t6_run",  {31'b0, Run}, 32'd0);
    check("t6_din",  {16'b0, DIN}, 32'd0);
    check("t6_busy", {31'b0, Busy}, 32'd0);
    check("t6_pc",   {27'b0, MemAddr}, 32'd0);
    step();
    Resetn = 1'b1;
    nodone = 1'b0;
    step();

    // Randomized programs against an interpreter reference
    for (int t = 0; t < 20; t++) begin
      do_reset();
      for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
      for (int i = 0; i < 8; i++) refR[i] = '0;
      sa  = AW'($urandom);
      a   = sa;
      ni  = 1 + int'($urandom_range(0, 5));
      lat = 0;
      for (int i = 0; i < ni; i++) begin
        op = int'($urandom_range(0, 3));
        x  = int'($urandom_range(0, 7));
        y  = int'($urandom_range(0, 7));
        rom[a] = 16'((op << 6) | (x << 3) | y);
        a = a + 1'b1;
        case (op)
          0: begin refR[x] = refR[y]; lat += 3; end
          1: begin
            imm = 16'($urandom);
            rom[a] = imm;
            a = a + 1'b1;
            refR[x] = imm;
            lat += 3;
          end
          2: begin refR[x] = refR[x] + refR[y]; lat += 5; end
          default: begin refR[x] = refR[x] - refR[y]; lat += 5; end
        endcase
      end
      rom[a] = 16'h01C0;
      a = a + 1'b1;
      pulse_start(sa);
      n = 0;
      while (Busy && n < 100) begin
        step();
        n++;
      end
      check("rnd_busy_cycles", n, lat + 2);
      check("rnd_halted", {31'b0, Halted}, 32'd1);
      check("rnd_cnt", {16'b0, InstrCount}, ni);
      check("rnd_pc", {27'b0, MemAddr}, {27'b0, a});
      for (int i = 0; i < 8; i++)
        check("rnd_reg", {16'b0, R[i]}, {16'b0, refR[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
